// File: rtl/game_pkg.sv
// Shared game constants: phase encoding, status widths and playfield geometry.
package game_pkg;

  typedef enum logic [2:0] {
    PH_ATTRACT = 3'd0,
    PH_SERVE   = 3'd1,
    PH_PLAY    = 3'd2,
    PH_LOST    = 3'd3,
    PH_OVER    = 3'd4,
    PH_PAUSED  = 3'd5
  } phase_e;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned LEVEL_W = 3;

  // Playfield geometry shared by the game logic and the flow controller
  localparam int unsigned PADDLE_LENGTH_PIXEL = 64;
  localparam int unsigned gameBeginXPixel     = 16;
  localparam int unsigned gameEndXPixel       = 624;
  localparam int unsigned paddleYPixel        = 448;
  localparam int unsigned ballSizePixel       = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Update handshake between the flow controller (master) and per-frame game logic (slave).
interface game_flow_controller_if;
  logic START_UPDATE;
  logic BALL_HOLD;
  logic LOGIC_RESET;
  logic BALL_LOST;
  logic BRICKS_CLEARED;

  modport master (
    output START_UPDATE, BALL_HOLD, LOGIC_RESET,
    input  BALL_LOST, BRICKS_CLEARED
  );

  modport slave (
    input  START_UPDATE, BALL_HOLD, LOGIC_RESET,
    output BALL_LOST, BRICKS_CLEARED
  );
endinterface

// File: rtl/game_flow_controller_frame_delay_counter.sv
// Saturating frame counter shared by the LOST and OVER delays; done once count reaches target.
module frame_delay_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] target,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      count_q <= '0;
    end else if (tick && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign done = (count_q >= target);

endmodule

// File: rtl/game_flow_controller.sv
// Game-phase sequencer: gates frame ticks into update pulses and tracks lives/level.
// Optional pause state enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT        = 3,
  parameter int unsigned LEVEL_MAX         = 7,
  parameter int unsigned LOST_DELAY_FRAMES = 90,
  parameter int unsigned OVER_DELAY_FRAMES = 300,
  parameter int unsigned UPDATE_CYCLES     = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FRAME_TICK,
  input  logic                  BTN_START,
  input  logic                  BTN_RELEASE,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic                  BTN_PAUSE,
`endif
  game_flow_controller_if.master game_if,
  output logic [LIVES_W-1:0]    LIVES,
  output logic [LEVEL_W-1:0]    LEVEL,
  output logic                  GAME_OVER,
  output logic [PHASE_W-1:0]    PHASE
);

  localparam int unsigned CNT_W  = $clog2(max_u(LOST_DELAY_FRAMES, OVER_DELAY_FRAMES) + 1);
  localparam int unsigned BUSY_W = $clog2(UPDATE_CYCLES + 1);

  phase_e               state_q, state_next;
  logic [LIVES_W-1:0]   lives_q, lives_next;
  logic [LEVEL_W-1:0]   level_q, level_next;
  logic [BUSY_W-1:0]    busy_q;
  logic                 upd_q, hold_q, hold_next, lreset_q, lreset_next, over_q;
  logic                 start_q, release_q, start_rise, release_rise, upd_fire;
  logic                 cnt_clear, cnt_tick, cnt_done;
  logic [CNT_W-1:0]     cnt_target;

  assign start_rise   = BTN_START & ~start_q;
  assign release_rise = BTN_RELEASE & ~release_q;
  assign upd_fire     = FRAME_TICK && (busy_q == '0) &&
                        ((state_q == PH_SERVE) || (state_q == PH_PLAY));

`ifdef GAME_FLOW_PAUSE_EN
  logic   pause_q, pause_rise;
  phase_e ret_q;

  assign pause_rise = BTN_PAUSE & ~pause_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pause_q <= 1'b0;
      ret_q   <= PH_SERVE;
    end else begin
      pause_q <= BTN_PAUSE;
      if ((state_next == PH_PAUSED) && (state_q != PH_PAUSED)) ret_q <= state_q;
    end
  end
`endif

  // One counter serves both delays; any phase change restarts it from zero
  assign cnt_clear  = (state_next != state_q);
  assign cnt_tick   = FRAME_TICK && ((state_q == PH_LOST) || (state_q == PH_OVER));
  assign cnt_target = (state_q == PH_OVER) ? CNT_W'(OVER_DELAY_FRAMES) : CNT_W'(LOST_DELAY_FRAMES);

  frame_delay_counter #(.WIDTH(CNT_W)) u_frame_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (cnt_clear),
    .tick   (cnt_tick),
    .target (cnt_target),
    .done   (cnt_done)
  );

  always_comb begin
    state_next  = state_q;
    lives_next  = lives_q;
    level_next  = level_q;
    lreset_next = 1'b0;
    case (state_q)
      PH_ATTRACT: begin
        if (start_rise) begin
          lives_next  = LIVES_W'(LIVES_INIT);
          level_next  = LEVEL_W'(1);
          lreset_next = 1'b1;
          state_next  = PH_SERVE;
        end
      end
      PH_SERVE: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (pause_rise) state_next = PH_PAUSED;
        else
`endif
        if (release_rise) state_next = PH_PLAY;
      end
      PH_PLAY: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (pause_rise) state_next = PH_PAUSED;
        else
`endif
        // Game-logic status is only trusted outside the update busy window
        if (busy_q == '0) begin
          if (game_if.BALL_LOST) begin
            lives_next = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
            state_next = PH_LOST;
          end else if (game_if.BRICKS_CLEARED) begin
            level_next  = (level_q == LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(1) : level_q + LEVEL_W'(1);
            lreset_next = 1'b1;
            state_next  = PH_SERVE;
          end
        end
      end
      PH_LOST: begin
        if (cnt_done) state_next = (lives_q == '0) ? PH_OVER : PH_SERVE;
      end
      PH_OVER: begin
        if (cnt_done || start_rise) state_next = PH_ATTRACT;
      end
`ifdef GAME_FLOW_PAUSE_EN
      PH_PAUSED: begin
        if (pause_rise) state_next = ret_q;
      end
`endif
      default: state_next = PH_ATTRACT;
    endcase

    hold_next = (state_next != PH_PLAY);
`ifdef GAME_FLOW_PAUSE_EN
    if (state_next == PH_PAUSED) hold_next = hold_q;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= PH_ATTRACT;
      lives_q   <= '0;
      level_q   <= LEVEL_W'(1);
      busy_q    <= '0;
      upd_q     <= 1'b0;
      hold_q    <= 1'b1;
      lreset_q  <= 1'b0;
      over_q    <= 1'b0;
      start_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      lives_q   <= lives_next;
      level_q   <= level_next;
      upd_q     <= upd_fire;
      hold_q    <= hold_next;
      lreset_q  <= lreset_next;
      over_q    <= (state_next == PH_OVER);
      start_q   <= BTN_START;
      release_q <= BTN_RELEASE;
      if (upd_fire)            busy_q <= BUSY_W'(UPDATE_CYCLES);
      else if (busy_q != '0)   busy_q <= busy_q - BUSY_W'(1);
    end
  end

  assign game_if.START_UPDATE = upd_q;
  assign game_if.BALL_HOLD    = hold_q;
  assign game_if.LOGIC_RESET  = lreset_q;
  assign LIVES                = lives_q;
  assign LEVEL                = level_q;
  assign GAME_OVER            = over_q;
  assign PHASE                = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed + randomized bench for game_flow_controller against a cycle-level behavioural model.
module tb_game_flow_controller;

  localparam int LI = 3, LM = 7, LD = 90, OD = 300, UC = 3;
  localparam int ATTRACT = 0, SERVE = 1, PLAY = 2, LOST = 3, OVER = 4, PAUSED = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, b_start, b_rel, b_lost, b_clr, b_pause;
  logic [2:0] lives, level, phase;
  logic game_over;

  game_flow_controller_if gif();
  assign gif.BALL_LOST      = b_lost;
  assign gif.BRICKS_CLEARED = b_clr;

  game_flow_controller #(
    .LIVES_INIT(LI), .LEVEL_MAX(LM), .LOST_DELAY_FRAMES(LD),
    .OVER_DELAY_FRAMES(OD), .UPDATE_CYCLES(UC)
  ) dut (
    .CLK(clk), .RESET(rst), .FRAME_TICK(tick), .BTN_START(b_start), .BTN_RELEASE(b_rel),
`ifdef GAME_FLOW_PAUSE_EN
    .BTN_PAUSE(b_pause),
`endif
    .game_if(gif), .LIVES(lives), .LEVEL(level), .GAME_OVER(game_over), .PHASE(phase)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;

  // Behavioural model: what the outputs must be after the next clock edge
  int m_phase, m_lives, m_level, m_busy, m_frames, m_ret;
  bit m_upd, m_hold, m_lres, p_start, p_rel, p_pause;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit sr, rr, pr, fire;
    int np;
    if (rst) begin
      m_phase = ATTRACT; m_lives = 0; m_level = 1; m_busy = 0; m_frames = 0;
      m_upd = 0; m_hold = 1; m_lres = 0; p_start = 0; p_rel = 0; p_pause = 0; m_ret = SERVE;
      return;
    end
    sr = b_start && !p_start;
    rr = b_rel && !p_rel;
    pr = b_pause && !p_pause;
    fire = tick && (m_busy == 0) && (m_phase == SERVE || m_phase == PLAY);
    np = m_phase;
    m_lres = 0;
    if ((m_phase == SERVE || m_phase == PLAY) && pr) begin
      m_ret = m_phase;
      np = PAUSED;
    end else begin
      case (m_phase)
        ATTRACT: if (sr) begin m_lives = LI; m_level = 1; m_lres = 1; np = SERVE; end
        SERVE:   if (rr) np = PLAY;
        PLAY: begin
          if (m_busy == 0 && b_lost) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            np = LOST;
          end else if (m_busy == 0 && b_clr) begin
            m_level = m_level % LM + 1;
            m_lres = 1;
            np = SERVE;
          end
        end
        LOST:   if (m_frames >= LD) np = (m_lives == 0) ? OVER : SERVE;
        OVER:   if (m_frames >= OD || sr) np = ATTRACT;
        PAUSED: if (pr) np = m_ret;
        default: ;
      endcase
    end
    if (np != m_phase) m_frames = 0;
    else if (tick && (m_phase == LOST || m_phase == OVER)) m_frames++;
    m_busy = fire ? UC : ((m_busy > 0) ? m_busy - 1 : 0);
    m_upd = fire;
    if (np != PAUSED) m_hold = (np != PLAY);
    m_phase = np;
    p_start = b_start; p_rel = b_rel; p_pause = b_pause;
  endtask

  task automatic compare_all();
    check("phase", phase, m_phase);
    check("lives", lives, m_lives);
    check("level", level, m_level);
    check("start_update", gif.START_UPDATE, m_upd);
    check("ball_hold", gif.BALL_HOLD, m_hold);
    check("logic_reset", gif.LOGIC_RESET, m_lres);
    check("game_over", game_over, m_phase == OVER);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_tick(input int n);
    repeat (n) begin tick = 1; cyc(); tick = 0; cyc(); end
  endtask

  task automatic press_start();
    b_start = 1; cyc(); b_start = 0; cyc();
  endtask

  task automatic press_rel();
    b_rel = 1; cyc(); b_rel = 0; cyc();
  endtask

  initial begin
    rst = 1; tick = 0; b_start = 0; b_rel = 0; b_lost = 0; b_clr = 0; b_pause = 0;
    cyc(); cyc();
    rst = 0; cyc();
    check("rst_phase", phase, 0);
    check("rst_lives", lives, 0);
    check("rst_level", level, 1);
    check("rst_hold", gif.BALL_HOLD, 1);
    check("rst_upd", gif.START_UPDATE, 0);

    // Game start and first update pulse
    b_start = 1; cyc();
    check("t1_lreset", gif.LOGIC_RESET, 1);
    check("t1_lives", lives, 3);
    check("t1_phase", phase, 1);
    b_start = 0; cyc();
    check("t1_lreset_width", gif.LOGIC_RESET, 0);
    tick = 1; cyc(); tick = 0;
    check("t1_upd", gif.START_UPDATE, 1);
    cyc();
    check("t1_upd_width", gif.START_UPDATE, 0);
    repeat (4) cyc();

    // Tick during busy window is dropped
    press_rel();
    check("t2_phase", phase, 2);
    check("t2_hold", gif.BALL_HOLD, 0);
    tick = 1; cyc(); tick = 0;
    check("t2_first", gif.START_UPDATE, 1);
    cyc();
    tick = 1; cyc(); tick = 0;
    check("t2_dropped", gif.START_UPDATE, 0);
    cyc();
    tick = 1; cyc(); tick = 0;
    check("t2_after_busy", gif.START_UPDATE, 1);
    repeat (4) cyc();

    // Lose all lives, LOST and OVER delays
    repeat (2) begin
      b_lost = 1; cyc(); b_lost = 0;
      check("t3_lost", phase, 3);
      pulse_tick(LD);
      check("t3_reserve", phase, 1);
      press_rel();
    end
    b_lost = 1; cyc(); b_lost = 0;
    check("t3_lives0", lives, 0);
    pulse_tick(LD - 1);
    check("t3_lost_edge", phase, 3);
    pulse_tick(1);
    check("t3_over", phase, 4);
    check("t3_game_over", game_over, 1);
    pulse_tick(OD - 1);
    check("t3_over_edge", phase, 4);
    pulse_tick(1);
    check("t3_attract", phase, 0);

    // Level wrap and simultaneous lost/cleared
    press_start();
    for (int i = 2; i <= LM; i++) begin
      press_rel();
      b_clr = 1; cyc(); b_clr = 0; cyc();
      check("t4_level", level, i);
    end
    press_rel();
    b_clr = 1; cyc(); b_clr = 0;
    check("t4_wrap", level, 1);
    check("t4_wrap_lreset", gif.LOGIC_RESET, 1);
    check("t4_wrap_phase", phase, 1);
    cyc();
    press_rel();
    b_lost = 1; b_clr = 1; cyc(); b_lost = 0; b_clr = 0;
    check("t4_both_phase", phase, 3);
    check("t4_both_level", level, 1);

    // Held release button and reset mid-update
    rst = 1; cyc(); rst = 0; cyc();
    b_rel = 1;
    press_start();
    repeat (5) cyc();
    check("t5_held", phase, 1);
    b_rel = 0; cyc();
    check("t5_released", phase, 1);
    press_rel();
    check("t5_play", phase, 2);
    tick = 1; cyc(); tick = 0;
    check("t5_upd", gif.START_UPDATE, 1);
    rst = 1; cyc(); rst = 0;
    check("t5_rst_upd", gif.START_UPDATE, 0);
    check("t5_rst_phase", phase, 0);
    check("t5_rst_lives", lives, 0);
    repeat (5) cyc();

`ifdef GAME_FLOW_PAUSE_EN
    press_start();
    press_rel();
    b_pause = 1; cyc(); b_pause = 0;
    check("t6_paused", phase, 5);
    pulse_tick(10);
    b_lost = 1; cyc(); b_lost = 0; cyc();
    check("t6_lost_ignored", phase, 5);
    b_pause = 1; cyc(); b_pause = 0;
    check("t6_resume", phase, 2);
    cyc();
`endif

    // Randomized traffic
    repeat (4000) begin
      tick = ($urandom_range(3) == 0);
      if ($urandom_range(19) == 0) b_start = ~b_start;
      if ($urandom_range(5) == 0) b_rel = ~b_rel;
      b_lost = ($urandom_range(39) == 0);
      b_clr = ($urandom_range(59) == 0);
      rst = ($urandom_range(999) == 0);
`ifdef GAME_FLOW_PAUSE_EN
      if ($urandom_range(49) == 0) b_pause = ~b_pause;
`endif
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
